uart_case_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_byte_fifo.sv | 88 ++++++++
 rtl/uart_case_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_uart_case_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART case-converter controller: transform mode
// encodings, controller FSM states and the ASCII constants used by the
// transform and the optional CR->CRLF expansion.
package uart_pkg;

    // Case transform selection (i_mode)
    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_UPPER  = 2'b01;
    localparam logic [1:0] MODE_LOWER  = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    // ASCII constants
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] CASE_DELTA = 8'h20;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between the receive-capture stage and the transmit sequencer.
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// o_count is a register holding the occupancy after this cycle's push/pop.
// A push into a full FIFO is accepted only when a pop frees a slot in the
// same cycle; otherwise it is ignored here (the caller accounts the drop).
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [7:0]    i_push_data,
    input  logic          i_pop,
    output logic [7:0]    o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wr_q;
    logic [AW:0]   rd_q;
    logic [AW:0]   wr_d;
    logic [AW:0]   rd_d;
    logic [AW:0]   occ_s;
    logic [CW-1:0] count_q;
    logic          full_s;
    logic          empty_s;
    logic          pop_ok_s;
    logic          push_ok_s;

    assign empty_s   = (wr_q == rd_q);
    assign full_s    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok_s  = i_pop & ~empty_s;
    assign push_ok_s = i_push & (~full_s | pop_ok_s);

    // Next pointer values and resulting occupancy
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok_s) begin
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_d = wr_q;
        end
        if (pop_ok_s) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_d = rd_q;
        end
        occ_s = wr_d - rd_d;
    end

    // Pointer and occupancy registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q    <= {(AW+1){1'b0}};
            rd_q    <= {(AW+1){1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= CW'(occ_s);
        end
    end

    // Storage array write port
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push_ok_s) begin
            mem_q[wr_q[AW-1:0]] <= i_push_data;
        end
    end

    assign o_head  = mem_q[rd_q[AW-1:0]];
    assign o_count = count_q;
    assign o_full  = full_s;
    assign o_empty = empty_s;

endmodule

// File: rtl/uart_case_ctrl.sv
// Controller between the UART receiver and transmitter of the case-converter
// path. Each rising edge of i_rx_valid captures one byte into a FIFO; the
// FSM pops bytes in arrival order, applies the case transform selected by
// i_mode and drives the transmitter with a one-cycle start pulse, waiting for
// the busy flag to rise and fall before the next byte.
// Optional feature macro: UART_CASE_CRLF_EN -- when defined, a transmitted
// 0x0D is automatically followed by an inserted 0x0A.
module uart_case_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_valid,
    input  logic [1:0]    i_mode,
    input  logic          i_tx_busy,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_start,
    output logic [CW-1:0] o_fifo_count,
    output logic          o_overflow,
    input  logic          i_clr_overflow,
    output logic [7:0]    o_drop_count
);

    // Case transform: only ASCII letters are affected; everything else passes.
    function automatic logic [7:0] case_xform(input logic [7:0] b, input logic [1:0] mode);
        logic       is_lower;
        logic       is_upper;
        logic [7:0] r;
        is_lower = (b >= 8'h61) && (b <= 8'h7A);
        is_upper = (b >= 8'h41) && (b <= 8'h5A);
        case (mode)
            MODE_PASS:   r = b;
            MODE_UPPER:  r = is_lower ? (b - CASE_DELTA) : b;
            MODE_LOWER:  r = is_upper ? (b + CASE_DELTA) : b;
            MODE_TOGGLE: r = is_lower ? (b - CASE_DELTA) : (is_upper ? (b + CASE_DELTA) : b);
            default:     r = b;
        endcase
        return r;
    endfunction

    logic          valid_q;
    logic          push_s;
    logic          push_q;
    logic [7:0]    push_data_q;

    logic [7:0]    fifo_head_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          pop_s;
    logic          drop_s;

    ctrl_state_e   state_q;
    ctrl_state_e   state_d;
    logic [7:0]    hold_q;
    logic [7:0]    hold_d;
    logic [7:0]    tx_data_q;
    logic [7:0]    tx_data_d;
    logic          tx_start_q;

    logic          overflow_q;
    logic          overflow_d;
    logic [7:0]    drop_cnt_q;
    logic [7:0]    drop_cnt_d;

    // Rising-edge detector on the receiver valid; resets high so a valid that
    // is already asserted when reset releases is not mistaken for a new byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b1;
        end else begin
            valid_q <= i_rx_valid;
        end
    end

    assign push_s = i_rx_valid & ~valid_q;

    // Capture stage: register the push and its byte before writing the FIFO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            push_q      <= 1'b0;
            push_data_q <= 8'h00;
        end else begin
            push_q      <= push_s;
            push_data_q <= push_s ? i_rx_data : push_data_q;
        end
    end

    uart_byte_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (push_q),
        .i_push_data (push_data_q),
        .i_pop       (pop_s),
        .o_head      (fifo_head_s),
        .o_count     (fifo_count_s),
        .o_full      (fifo_full_s),
        .o_empty     (fifo_empty_s)
    );

    // A push is lost only when the FIFO is full and no pop frees a slot
    assign drop_s = push_q & fifo_full_s & ~pop_s;

    // Transmit sequencer: next state, pop request and data/hold updates
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        tx_data_d = tx_data_q;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    hold_d  = fifo_head_s;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                tx_data_d = case_xform(hold_q, i_mode);
                state_d   = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
`ifdef UART_CASE_CRLF_EN
                    if (tx_data_q == ASCII_CR) begin
                        hold_d  = ASCII_LF;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; start pulse is registered and high only in START
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            hold_q     <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= (state_d == ST_START);
        end
    end

    // Overflow flag and saturating drop counter; clear wins over a drop
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (i_clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'h00;
        end else if (drop_s) begin
            overflow_d = 1'b1;
            drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : (drop_cnt_q + 8'h01);
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Overflow status registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_fifo_count = fifo_count_s;
    assign o_overflow   = overflow_q;
    assign o_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_uart_case_ctrl.sv
// Scoreboard bench for uart_case_ctrl: stimulus pushes hand-computed expected
// bytes into a queue, a monitor pops and compares on every start pulse, and a
// transmitter model answers each start with a busy window.
module tb_uart_case_ctrl;

    logic       i_clk;
    logic       i_rst_n;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [1:0] i_mode;
    logic       i_tx_busy;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic [3:0] o_fifo_count;
    logic       o_overflow;
    logic       i_clr_overflow;
    logic [7:0] o_drop_count;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         start_cnt = 0;
    int         last_start_cyc = -1;
    int         push_cyc = 0;
    int         busy_delay = 1;
    logic       prev_start = 1'b0;
    logic       model_busy = 1'b0;
    logic       stuck_busy = 1'b0;
    logic [7:0] exp_q[$];

    assign i_tx_busy = model_busy | stuck_busy;

    uart_case_ctrl #(.DEPTH(8), .CW(4)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .i_mode         (i_mode),
        .i_tx_busy      (i_tx_busy),
        .o_tx_data      (o_tx_data),
        .o_tx_start     (o_tx_start),
        .o_fifo_count   (o_fifo_count),
        .o_overflow     (o_overflow),
        .i_clr_overflow (i_clr_overflow),
        .o_drop_count   (o_drop_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every start pulse is compared against the scoreboard head
    always @(negedge i_clk) begin
        if (o_tx_start === 1'b1) begin
            start_cnt++;
            last_start_cyc = cyc;
            check("start_one_cycle", int'(prev_start), 0);
            check("start_while_busy", int'(i_tx_busy), 0);
            check("start_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                check("tx_data", int'(o_tx_data), int'(exp_q.pop_front()));
            end
        end
        prev_start = o_tx_start;
    end

    // Transmitter model: busy rises busy_delay cycles after start, lasts 10
    always begin
        @(negedge i_clk);
        if (o_tx_start === 1'b1) begin
            repeat (busy_delay) @(posedge i_clk);
            #1 model_busy = 1'b1;
            repeat (10) @(posedge i_clk);
            #1 model_busy = 1'b0;
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge i_clk);
        #1;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        push_cyc   = cyc;
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || i_tx_busy) && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        repeat (16) @(negedge i_clk);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int s0;
        int peak;
        int n;
        logic [7:0] b;
        i_rst_n        = 1'b0;
        i_rx_data      = 8'h00;
        i_rx_valid     = 1'b0;
        i_mode         = 2'b00;
        i_clr_overflow = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_tx_data", int'(o_tx_data), 0);
        check("rst_tx_start", int'(o_tx_start), 0);
        check("rst_count", int'(o_fifo_count), 0);
        check("rst_overflow", int'(o_overflow), 0);
        check("rst_drops", int'(o_drop_count), 0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);

        // 1: upper-case a single byte, check latency and single pulse
        i_mode = 2'b01;
        s0 = start_cnt;
        exp_q.push_back(8'h41);
        send(8'h61);
        drain("t1_drain");
        check("t1_starts", start_cnt - s0, 1);
        check("t1_latency", last_start_cyc - push_cyc, 4);

        // 2: toggle mode, order preserved, starts gated by busy
        i_mode = 2'b11;
        s0 = start_cnt;
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h31);
        send(8'h41);
        send(8'h7A);
        send(8'h31);
        drain("t2_drain");
        check("t2_starts", start_cnt - s0, 3);

        // 3: valid held high for 50 cycles yields exactly one byte
        i_mode = 2'b00;
        s0 = start_cnt;
        peak = 0;
        exp_q.push_back(8'h5A);
        @(posedge i_clk);
        #1;
        i_rx_data  = 8'h5A;
        i_rx_valid = 1'b1;
        repeat (50) begin
            @(negedge i_clk);
            if (int'(o_fifo_count) > peak) peak = int'(o_fifo_count);
        end
        @(posedge i_clk);
        #1 i_rx_valid = 1'b0;
        drain("t3_drain");
        check("t3_peak_count", peak, 1);
        check("t3_starts", start_cnt - s0, 1);

        // 4: overflow with transmitter stuck busy
        s0 = start_cnt;
        exp_q.push_back(8'h40);
        send(8'h40);
        n = 0;
        while (o_tx_start !== 1'b1 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check("t4_blocker_started", int'(n < 20), 1);
        @(posedge i_clk);
        #1 stuck_busy = 1'b1;
        repeat (4) @(posedge i_clk);
        for (int i = 0; i < 10; i++) begin
            b = 8'h30 + 8'(i);
            if (i < 8) exp_q.push_back(b);
            send(b);
        end
        repeat (4) @(negedge i_clk);
        check("t4_count_full", int'(o_fifo_count), 8);
        check("t4_overflow", int'(o_overflow), 1);
        check("t4_drops", int'(o_drop_count), 2);
        @(posedge i_clk);
        #1 i_clr_overflow = 1'b1;
        @(posedge i_clk);
        #1 i_clr_overflow = 1'b0;
        @(negedge i_clk);
        check("t4_clr_overflow", int'(o_overflow), 0);
        check("t4_clr_drops", int'(o_drop_count), 0);
        check("t4_count_kept", int'(o_fifo_count), 8);
        for (int i = 0; i < 300; i++) send(8'h20);
        repeat (3) @(negedge i_clk);
        check("t4_drops_saturate", int'(o_drop_count), 255);
        check("t4_overflow_again", int'(o_overflow), 1);
        // clear in the very cycle a drop happens: clear wins
        @(posedge i_clk);
        #1;
        i_rx_data  = 8'h21;
        i_rx_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_rx_valid     = 1'b0;
        i_clr_overflow = 1'b1;
        @(posedge i_clk);
        #1 i_clr_overflow = 1'b0;
        @(negedge i_clk);
        check("t4_clr_vs_drop_ovf", int'(o_overflow), 0);
        check("t4_clr_vs_drop_cnt", int'(o_drop_count), 0);
        @(posedge i_clk);
        #1 stuck_busy = 1'b0;
        drain("t4_drain");
        check("t4_starts", start_cnt - s0, 9);

        // 5: reset in WAIT_BUSY with bytes queued, valid held through release
        busy_delay = 30;
        s0 = start_cnt;
        exp_q.push_back(8'h61);
        send(8'h61);
        send(8'h62);
        send(8'h63);
        send(8'h64);
        repeat (3) @(negedge i_clk);
        check("t5_queued", int'(o_fifo_count), 3);
        check("t5_first_sent", exp_q.size(), 0);
        @(posedge i_clk);
        #1;
        i_rx_data  = 8'h65;
        i_rx_valid = 1'b1;
        i_rst_n    = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge i_clk);
        check("t5_rst_tx_data", int'(o_tx_data), 0);
        check("t5_rst_start", int'(o_tx_start), 0);
        check("t5_rst_count", int'(o_fifo_count), 0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        s0 = start_cnt;
        repeat (40) @(negedge i_clk);
        check("t5_no_start", start_cnt - s0, 0);
        check("t5_count_after", int'(o_fifo_count), 0);
        @(posedge i_clk);
        #1 i_rx_valid = 1'b0;
        repeat (20) @(negedge i_clk);
        busy_delay = 1;

        // 6: carriage return, optionally followed by an inserted line feed
        i_mode = 2'b00;
        s0 = start_cnt;
        exp_q.push_back(8'h0D);
`ifdef UART_CASE_CRLF_EN
        exp_q.push_back(8'h0A);
`endif
        send(8'h0D);
        drain("t6_drain");
`ifdef UART_CASE_CRLF_EN
        check("t6_starts", start_cnt - s0, 2);
`else
        check("t6_starts", start_cnt - s0, 1);
`endif
        check("t6_count", int'(o_fifo_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
